// File: rtl/mem_bus_rr_sched.sv
// Round-robin owner scheduler for the MCU external memory data bus.
// Grants one requester at a time and latches its direction. It inserts a
// turnaround gap between owners and preempts an owner that holds the bus too
// long while other ports wait.
// Optional feature macro: MBA_PRIO_EN makes port 0 urgent. Port 0 always wins
// when it requests and is never preempted. The round-robin pointer then
// covers ports 1..NREQ-1 only.
//
// state | meaning
// IDLE  | no owner, bus released, outputs cleared
// GRANT | one port owns the bus, hold timer watches other requesters
// TURN  | dead cycles between owners, waits for PHY drain
module mem_bus_rr_sched #(
    parameter int NREQ      = 4,
    parameter int TURN_CYC  = 2,
    parameter int MAX_HOLD  = 16,
    parameter int DRAIN_MAX = 3
) (
    input  logic                    clk_166M66,
    input  logic                    mcu_sys_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ-1:0]         i_rw,
    input  logic                    i_status_bus_transmitting,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_owner,
    output logic                    o_data_bus_enable,
    output logic                    o_data_bus_rw,
    output logic                    o_drain_err
);

    localparam int IW       = $clog2(NREQ);
    localparam int TURN_MAX = TURN_CYC - 1 + DRAIN_MAX;
    localparam int HW       = $clog2(MAX_HOLD) + 1;
    localparam int TW       = $clog2(TURN_MAX + 1) + 1;
`ifdef MBA_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic              drain_q, drain_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TW-1:0]     turn_q, turn_d;

    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;
    logic              others;

    // Round-robin search from last_owner+1 upward; the nearest requester wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (i_req[cand] && !(PRIO && cand == '0)) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        if (PRIO && i_req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
    end

    // Next-state and registered-output computation for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        en_d    = en_q;
        rw_d    = rw_q;
        drain_d = 1'b0;
        hold_d  = hold_q;
        turn_d  = turn_q;
        others  = |(i_req & ~grant_q);

        unique case (state_q)
            IDLE, TURN: begin
                if (state_q == IDLE ||
                    (turn_q >= TW'(TURN_CYC - 1) && !i_status_bus_transmitting) ||
                    turn_q >= TW'(TURN_MAX)) begin
                    // Forced exit while PHY still busy is flagged as a drain error.
                    drain_d = (state_q == TURN) && i_status_bus_transmitting;
                    turn_d  = '0;
                    hold_d  = '0;
                    if (win_vld) begin
                        state_d = GRANT;
                        grant_d = NREQ'(1) << win_idx;
                        owner_d = win_idx;
                        en_d    = 1'b1;
                        rw_d    = i_rw[win_idx];
                        if (!(PRIO && win_idx == '0)) begin
                            last_d = win_idx;
                        end
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        en_d    = 1'b0;
                        rw_d    = 1'b0;
                    end
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            GRANT: begin
                if (!i_req[owner_q] ||
                    (others && hold_q == HW'(MAX_HOLD - 1) && !(PRIO && owner_q == '0))) begin
                    state_d = TURN;
                    grant_d = '0;
                    en_d    = 1'b0;
                    hold_d  = '0;
                    turn_d  = '0;
                end else if (others) begin
                    if (hold_q != HW'(MAX_HOLD - 1)) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    hold_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                en_d    = 1'b0;
                rw_d    = 1'b0;
                hold_d  = '0;
                turn_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            drain_q <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            drain_q <= drain_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign o_grant           = grant_q;
    assign o_owner           = owner_q;
    assign o_data_bus_enable = en_q;
    assign o_data_bus_rw     = rw_q;
    assign o_drain_err       = drain_q;

endmodule
